decode_issue: RTL and testbench

//  Producer end of the execution-stage control interface. Accepts {instr, pc} words over a valid/ready

---
 rtl/decode_issue.sv | 208 ++++++++++++++++++++
 tb/tb_decode_issue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decodes RV32I {instr, pc} words into the execution-stage
// control bundle. Issue is strictly in order through a 2-entry skid buffer.
// The head entry drives the outputs directly.
module decode_issue #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned CNT_W         = 32,
   parameter logic [2:0]  ILLEGAL_ALUOP = 3'b111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  address,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       aluop,
   output logic             alu_src,
   output logic [2:0]       fn3,
   output logic             fn7_5,
   output logic [6:0]       imm11_5,
   output logic             branch,
   output logic             mux_inp,
   output logic             illegal,
   output logic [CNT_W-1:0] issue_count
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_IALU   = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } opcode_t;

   typedef enum logic [1:0] {
      OCC_0 = 2'd0,
      OCC_1 = 2'd1,
      OCC_2 = 2'd2
   } occ_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      aluop;
      logic            alu_src;
      logic [2:0]      fn3;
      logic            fn7_5;
      logic [6:0]      imm11_5;
      logic            branch;
      logic            mux_inp;
      logic            illegal;
   } bundle_t;

   occ_t             r_occ;
   bundle_t          r_head;
   bundle_t          r_skid;
   logic [CNT_W-1:0] r_cnt;

   bundle_t          w_dec;
   logic             w_accept;
   logic             w_issue;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_s;
   logic [XLEN-1:0]  w_imm_b;
   logic [XLEN-1:0]  w_imm_u;
   logic [XLEN-1:0]  w_imm_j;

   // Readiness depends only on registered occupancy, never on out_ready.
   assign in_ready  = ~rst & (r_occ != OCC_2);
   assign out_valid = (r_occ != OCC_0);
   assign w_accept  = in_valid & in_ready;
   assign w_issue   = out_valid & out_ready;

   assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
   assign w_imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

   // Decode the incoming word into a control bundle before it is stored.
   always_comb begin
      w_dec         = '0;
      w_dec.pc      = in_pc;
      w_dec.fn3     = in_instr[14:12];
      w_dec.imm11_5 = in_instr[31:25];
      w_dec.alu_src = 1'b1;
      case (in_instr[6:0])
         OP_R: begin
            w_dec.aluop   = 3'b000;
            w_dec.alu_src = 1'b0;
            w_dec.fn7_5   = in_instr[30];
         end
         OP_IALU: begin
            w_dec.aluop = 3'b001;
            w_dec.imm   = w_imm_i;
            w_dec.fn7_5 = (in_instr[14:12] == 3'b101) ? in_instr[30] : 1'b0;
         end
         OP_LOAD: begin
            w_dec.aluop = 3'b010;
            w_dec.imm   = w_imm_i;
         end
         OP_STORE: begin
            w_dec.aluop = 3'b011;
            w_dec.imm   = w_imm_s;
         end
         OP_BRANCH: begin
            w_dec.aluop   = 3'b100;
            w_dec.alu_src = 1'b0;
            w_dec.imm     = w_imm_b;
            w_dec.branch  = 1'b1;
         end
         OP_JAL: begin
            w_dec.aluop = 3'b101;
            w_dec.imm   = w_imm_j;
            w_dec.fn3   = 3'b000;
         end
         OP_JALR: begin
            w_dec.aluop   = 3'b001;
            w_dec.imm     = w_imm_i;
            w_dec.mux_inp = 1'b1;
         end
         OP_LUI: begin
            w_dec.aluop = 3'b110;
            w_dec.imm   = w_imm_u;
            w_dec.fn3   = 3'b000;
         end
         OP_AUIPC: begin
            w_dec.aluop = 3'b001;
            w_dec.imm   = w_imm_u;
            w_dec.fn3   = 3'b000;
         end
         default: begin
            // Undecodable: everything but the pc is cleared.
            w_dec.fn3     = 3'b000;
            w_dec.imm11_5 = 7'b0;
            w_dec.alu_src = 1'b0;
            w_dec.aluop   = ILLEGAL_ALUOP;
            w_dec.illegal = 1'b1;
         end
      endcase
   end

   // Skid-buffer occupancy FSM, entry storage and issue counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ  <= OCC_0;
         r_head <= '0;
         r_skid <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_issue)
            r_cnt <= r_cnt + CNT_W'(1);
         if (flush) begin
            r_occ <= OCC_0;
         end else begin
            case (r_occ)
               OCC_0: begin
                  if (w_accept) begin
                     r_head <= w_dec;
                     r_occ  <= OCC_1;
                  end
               end
               OCC_1: begin
                  // Issue and accept together: the new word replaces the head.
                  if (w_accept && w_issue) begin
                     r_head <= w_dec;
                  end else if (w_accept) begin
                     r_skid <= w_dec;
                     r_occ  <= OCC_2;
                  end else if (w_issue) begin
                     r_occ <= OCC_0;
                  end
               end
               OCC_2: begin
                  if (w_issue) begin
                     r_head <= r_skid;
                     r_occ  <= OCC_1;
                  end
               end
               default: r_occ <= OCC_0;
            endcase
         end
      end
   end

   assign address     = r_head.pc;
   assign imm_out     = r_head.imm;
   assign aluop       = r_head.aluop;
   assign alu_src     = r_head.alu_src;
   assign fn3         = r_head.fn3;
   assign fn7_5       = r_head.fn7_5;
   assign imm11_5     = r_head.imm11_5;
   assign branch      = r_head.branch;
   assign mux_inp     = r_head.mux_inp;
   assign illegal     = r_head.illegal;
   assign issue_count = r_cnt;

endmodule

// File: tb/tb_decode_issue.sv
// Directed testbench for decode_issue: a table of decoded words plus
// hand-written backpressure, flush and reset sequences. A second instance
// with a 2-bit counter shares the stimulus so counter wrap is observable.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] address;
   logic [31:0] imm_out;
   logic [2:0]  aluop;
   logic        alu_src;
   logic [2:0]  fn3;
   logic        fn7_5;
   logic [6:0]  imm11_5;
   logic        branch;
   logic        mux_inp;
   logic        illegal;
   logic [31:0] issue_count;

   logic        in_ready_w;
   logic        out_valid_w;
   logic [31:0] address_w;
   logic [31:0] imm_out_w;
   logic [2:0]  aluop_w;
   logic        alu_src_w;
   logic [2:0]  fn3_w;
   logic        fn7_5_w;
   logic [6:0]  imm11_5_w;
   logic        branch_w;
   logic        mux_inp_w;
   logic        illegal_w;
   logic [1:0]  issue_count_w;

   decode_issue #(.XLEN(32), .CNT_W(32), .ILLEGAL_ALUOP(3'b111)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .address(address),
      .imm_out(imm_out), .aluop(aluop), .alu_src(alu_src), .fn3(fn3),
      .fn7_5(fn7_5), .imm11_5(imm11_5), .branch(branch), .mux_inp(mux_inp),
      .illegal(illegal), .issue_count(issue_count)
   );

   decode_issue #(.XLEN(32), .CNT_W(2), .ILLEGAL_ALUOP(3'b111)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid_w), .out_ready(out_ready), .address(address_w),
      .imm_out(imm_out_w), .aluop(aluop_w), .alu_src(alu_src_w), .fn3(fn3_w),
      .fn7_5(fn7_5_w), .imm11_5(imm11_5_w), .branch(branch_w),
      .mux_inp(mux_inp_w), .illegal(illegal_w), .issue_count(issue_count_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  aluop;
      logic        src;
      logic [2:0]  fn3;
      logic        f7;
      logic [6:0]  i115;
      logic        br;
      logic        mux;
      logic        ill;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   int n_vec = 0;
   int n_err = 0;
   int exp_cnt = 0;

   function automatic logic [82:0] act_main();
      return {out_valid, address, imm_out, aluop, alu_src, fn3, fn7_5,
              imm11_5, branch, mux_inp, illegal};
   endfunction

   function automatic logic [82:0] act_wrap();
      return {out_valid_w, address_w, imm_out_w, aluop_w, alu_src_w, fn3_w,
              fn7_5_w, imm11_5_w, branch_w, mux_inp_w, illegal_w};
   endfunction

   function automatic logic [82:0] exp_of(input vec_t v);
      return {1'b1, v.pc, v.imm, v.aluop, v.src, v.fn3, v.f7, v.i115,
              v.br, v.mux, v.ill};
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           instr         pc          imm          aluop src fn3  f7   i115   br   mux  ill
      vecs[0]  = '{32'h002081B3, 32'h100, 32'h00000000, 3'd0, 1'b0, 3'd0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0}; // ADD
      vecs[1]  = '{32'h402081B3, 32'h104, 32'h00000000, 3'd0, 1'b0, 3'd0, 1'b1, 7'h20, 1'b0, 1'b0, 1'b0}; // SUB
      vecs[2]  = '{32'h01000093, 32'h108, 32'h00000010, 3'd1, 1'b1, 3'd0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0}; // ADDI
      vecs[3]  = '{32'h4030D093, 32'h10C, 32'h00000403, 3'd1, 1'b1, 3'd5, 1'b1, 7'h20, 1'b0, 1'b0, 1'b0}; // SRAI
      vecs[4]  = '{32'h00208863, 32'h1000, 32'h00000010, 3'd4, 1'b0, 3'd0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0}; // BEQ
      vecs[5]  = '{32'h010100E7, 32'h114, 32'h00000010, 3'd1, 1'b1, 3'd0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0}; // JALR
      vecs[6]  = '{32'h123450B7, 32'h118, 32'h12345000, 3'd6, 1'b1, 3'd0, 1'b0, 7'h09, 1'b0, 1'b0, 1'b0}; // LUI
      vecs[7]  = '{32'hFFC12083, 32'h11C, 32'hFFFFFFFC, 3'd2, 1'b1, 3'd2, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b0}; // LW -4
      vecs[8]  = '{32'hFE312C23, 32'h120, 32'hFFFFFFF8, 3'd3, 1'b1, 3'd2, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b0}; // SW -8
      vecs[9]  = '{32'hFE209CE3, 32'h124, 32'hFFFFFFF8, 3'd4, 1'b0, 3'd1, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b0}; // BNE -8
      vecs[10] = '{32'hFFDFF0EF, 32'h128, 32'hFFFFFFFC, 3'd5, 1'b1, 3'd0, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b0}; // JAL -4
      vecs[11] = '{32'h80000297, 32'h12C, 32'h80000000, 3'd1, 1'b1, 3'd0, 1'b0, 7'h40, 1'b0, 1'b0, 1'b0}; // AUIPC
      vecs[12] = '{32'h40008093, 32'h130, 32'h00000400, 3'd1, 1'b1, 3'd0, 1'b0, 7'h20, 1'b0, 1'b0, 1'b0}; // ADDI bit30
      vecs[13] = '{32'hFFFFFFFF, 32'h134, 32'h00000000, 3'd7, 1'b0, 3'd0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1}; // illegal

      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;

      // Reset state
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      tick();
      rst = 1'b0;
      #1;
      chk("rst_bundle", 128'(act_main()), 128'(0));
      chk("rst_count", 128'(issue_count), 128'(0));
      chk("rst_in_ready_after", 128'({in_ready, in_ready_w}), 128'(2'b11));

      // Streaming decode table at full throughput
      for (int i = 0; i < NV; i++) begin
         in_instr = vecs[i].instr; in_pc = vecs[i].pc;
         in_valid = 1'b1; out_ready = 1'b1;
         tick();
         chk($sformatf("vec%0d", i), 128'(act_main()), 128'(exp_of(vecs[i])));
         chk($sformatf("vec%0d_w", i), 128'(act_wrap()), 128'(exp_of(vecs[i])));
      end
      chk("stream_count_mid", 128'(issue_count), 128'(NV - 1));
      in_valid = 1'b0;
      tick();
      exp_cnt += NV;
      chk("stream_drain_valid", 128'(out_valid), 128'(0));
      chk("stream_count", 128'(issue_count), 128'(exp_cnt));

      // Backpressure: three words, two fit, then release in order
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h002081B3; in_pc = 32'h2000;
      tick();
      chk("bp_first", 128'({out_valid, in_ready, address}), 128'({2'b11, 32'h2000}));
      in_instr = 32'h01000093; in_pc = 32'h2004;
      tick();
      chk("bp_full", 128'({out_valid, in_ready, address}), 128'({2'b10, 32'h2000}));
      in_instr = 32'h123450B7; in_pc = 32'h2008;
      tick();
      chk("bp_hold", 128'({in_ready, address, aluop}), 128'({1'b0, 32'h2000, 3'd0}));
      out_ready = 1'b1;
      tick();
      exp_cnt += 1;
      chk("bp_rel1", 128'({out_valid, in_ready, address, aluop}), 128'({2'b11, 32'h2004, 3'd1}));
      tick();
      exp_cnt += 1;
      chk("bp_rel2", 128'({out_valid, address, imm_out}), 128'({1'b1, 32'h2008, 32'h12345000}));
      in_valid = 1'b0;
      tick();
      exp_cnt += 1;
      chk("bp_drain", 128'({out_valid, issue_count}), 128'({1'b0, 32'(exp_cnt)}));

      // Flush with both entries full and a word offered
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h002081B3; in_pc = 32'h3000;
      tick();
      in_pc = 32'h3004;
      tick();
      in_pc = 32'h3008; flush = 1'b1;
      tick();
      chk("fl_empty", 128'({out_valid, in_ready}), 128'(2'b01));
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      chk("fl_nothing_issued", 128'({out_valid, issue_count}), 128'({1'b0, 32'(exp_cnt)}));

      // Flush concurrent with an issue: issue counts, offered word dropped
      in_valid = 1'b1; in_pc = 32'h4000;
      tick();
      in_pc = 32'h4004; flush = 1'b1;
      tick();
      exp_cnt += 1;
      chk("fl_issue_valid", 128'(out_valid), 128'(0));
      flush = 1'b0; in_valid = 1'b0;
      tick(); tick();
      chk("fl_issue_count", 128'({out_valid, issue_count}), 128'({1'b0, 32'(exp_cnt)}));
      chk("wrap_count", 128'(issue_count_w), 128'(exp_cnt % 4));

      // Reset mid-stream with both entries occupied
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFC12083; in_pc = 32'h5000;
      tick();
      in_pc = 32'h5004;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 128'({in_ready, in_ready_w}), 128'(0));
      tick();
      exp_cnt = 0;
      chk("rst_mid_bundle", 128'(act_main()), 128'(0));
      chk("rst_mid_count", 128'({issue_count, issue_count_w}), 128'(0));
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("rst_mid_after", 128'({out_valid, in_ready}), 128'(2'b01));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
